// File: rtl/io_bus_responder.sv
// Single-page memory-mapped I/O responder: wait-stated bus handshake, SCRATCH
// register, STATUS register and a TX FIFO that drains toward a peripheral.
module io_bus_responder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [19:0] IO_PAGE     = 20'h40000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic        b_read_i,
    input  logic        b_write_i,
    output logic        b_ack_o,
    output logic [31:0] b_data_o,
    output logic        p_valid_o,
    output logic [31:0] p_data_o,
    input  logic        p_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = 4;
    localparam logic [11:0] OFF_TX = 12'h000;
    localparam logic [11:0] OFF_ST = 12'h004;
    localparam logic [11:0] OFF_SC = 12'h008;
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t          state;
    state_t          state_nx;
    logic [WW-1:0]   cnt;
    logic [WW-1:0]   cnt_nx;
    logic            req;
    logic            commit;

    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic [31:0]     scratch;

    logic [11:0]     off;
    logic            is_write;
    logic            is_read;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            push_ok;
    logic            ovf_set;
    logic            ovf_clr;
    logic [31:0]     status;
    logic [31:0]     rdata;

    assign req = (b_read_i | b_write_i) & (b_addr_i[31:12] == IO_PAGE);

    // Handshake sequencing; commit marks the edge that enters ACK.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        state_nx = ST_ACK;
                        commit   = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WW'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt <= WW'(1)) begin
                    state_nx = ST_ACK;
                    cnt_nx   = '0;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - WW'(1);
                end
            end
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Register decode and FIFO control; a simultaneous read+write is a write.
    always_comb begin
        off      = b_addr_i[11:0];
        is_write = b_write_i;
        is_read  = b_read_i & ~b_write_i;
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        pop      = p_valid_o & p_ready_i;
        push     = commit & is_write & (off == OFF_TX);
        push_ok  = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        ovf_clr  = commit & is_write & (off == OFF_ST) & b_data_i[8];

        status      = '0;
        status[4:0] = 5'(count);
        status[5]   = empty;
        status[6]   = full;
        status[8]   = ovf;

        rdata = '0;
        if (is_read) begin
            case (off)
                OFF_ST:  rdata = status;
                OFF_SC:  rdata = scratch;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            scratch  <= '0;
            b_ack_o  <= 1'b0;
            b_data_o <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            b_ack_o  <= commit;
            b_data_o <= commit ? rdata : '0;
            if (commit & is_write & (off == OFF_SC)) begin
                scratch <= b_data_i;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= b_data_i;
        end
    end

    assign p_valid_o = (count != '0);
    assign p_data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: two instances on distinct pages (1 and 3 wait
// states), directed scenarios plus random traffic against a queue-based model.
module tb_io_bus_responder;

    localparam int unsigned DEPTH_A = 8;
    localparam int unsigned WS_A    = 1;
    localparam int unsigned DEPTH_B = 4;
    localparam int unsigned WS_B    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_read;
    logic        b_write;
    logic        p_ready;
    logic        p_ready_b;

    logic        ack_a;
    logic [31:0] data_a;
    logic        p_valid_a;
    logic [31:0] p_data_a;
    logic        ack_b;
    logic [31:0] data_b;
    logic        p_valid_b;
    logic [31:0] p_data_b;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] q[$];
    logic        m_ovf;
    logic [31:0] m_scr;
    logic [31:0] m_scr_b;
    logic [31:0] exp_b;
    bit          rand_ready;

    always #5 clk = ~clk;

    io_bus_responder #(.DEPTH(DEPTH_A), .WAIT_STATES(WS_A), .IO_PAGE(20'h40000)) dut_a (
        .clk(clk), .rst_n(rst_n), .b_addr_i(b_addr), .b_data_i(b_wdata),
        .b_read_i(b_read), .b_write_i(b_write), .b_ack_o(ack_a), .b_data_o(data_a),
        .p_valid_o(p_valid_a), .p_data_o(p_data_a), .p_ready_i(p_ready)
    );

    io_bus_responder #(.DEPTH(DEPTH_B), .WAIT_STATES(WS_B), .IO_PAGE(20'h50000)) dut_b (
        .clk(clk), .rst_n(rst_n), .b_addr_i(b_addr), .b_data_i(b_wdata),
        .b_read_i(b_read), .b_write_i(b_write), .b_ack_o(ack_b), .b_data_o(data_b),
        .p_valid_o(p_valid_b), .p_data_o(p_data_b), .p_ready_i(p_ready_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] a_read(input logic [11:0] off);
        logic [31:0] s;
        s = '0;
        case (off)
            12'h004: begin
                s[4:0] = 5'(q.size());
                s[5]   = (q.size() == 0);
                s[6]   = (q.size() == DEPTH_A);
                s[8]   = m_ovf;
            end
            12'h008: s = m_scr;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] b_read_model(input logic [11:0] off);
        if (off == 12'h004) return 32'h0000_0020;
        if (off == 12'h008) return m_scr_b;
        return 32'h0;
    endfunction

    // One clock; ca/cb say whether this edge is the commit edge for A/B.
    task automatic tick(input bit ca, input bit cb);
        bit          pop_m;
        bit          push_m;
        logic [31:0] rexp;
        logic [31:0] wd;
        logic [11:0] off;
        if (rand_ready) p_ready = ($urandom_range(0, 3) == 0);
        pop_m  = (q.size() != 0) && (p_ready == 1'b1);
        push_m = 1'b0;
        rexp   = '0;
        off    = b_addr[11:0];
        wd     = b_wdata;
        if (ca) begin
            if (b_write) begin
                case (off)
                    12'h000: if (q.size() < DEPTH_A || pop_m) push_m = 1'b1; else m_ovf = 1'b1;
                    12'h004: if (wd[8]) m_ovf = 1'b0;
                    12'h008: m_scr = wd;
                    default: ;
                endcase
            end else if (b_read) begin
                rexp = a_read(off);
            end
        end
        @(posedge clk);
        #1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(wd);
        check("a_ack", 32'(ack_a), 32'(ca));
        check("a_rdata", data_a, rexp);
        check("a_pvalid", 32'(p_valid_a), 32'(q.size() != 0));
        if (q.size() != 0) check("a_pdata", p_data_a, q[0]);
        check("b_ack", 32'(ack_b), 32'(cb));
        check("b_rdata", data_b, cb ? exp_b : 32'h0);
        check("b_pvalid", 32'(p_valid_b), 32'h0);
    endtask

    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] rdat);
        int lat;
        lat     = 1 + int'(sel ? WS_B : WS_A);
        b_addr  = addr;
        b_wdata = data;
        b_read  = rd;
        b_write = wr;
        rdat    = '0;
        for (int k = 1; k <= lat; k++) begin
            if (sel && k == lat) begin
                exp_b = '0;
                if (wr) begin
                    if (addr[11:0] == 12'h008) m_scr_b = data;
                end else if (rd) begin
                    exp_b = b_read_model(addr[11:0]);
                end
            end
            tick(!sel && k == lat, sel && k == lat);
            if (k == lat) rdat = sel ? data_b : data_a;
        end
        b_read  = 1'b0;
        b_write = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic no_ack(input logic [31:0] addr, input int n);
        b_addr = addr;
        b_read = 1'b1;
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
        b_read = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic abort_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
        b_addr  = addr;
        b_wdata = data;
        b_write = 1'b1;
        for (int k = 0; k < hold; k++) tick(1'b0, 1'b0);
        b_write = 1'b0;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_ovf   = 1'b0;
        m_scr   = '0;
        m_scr_b = '0;
        check("rst_a_ack", 32'(ack_a), 32'h0);
        check("rst_a_data", data_a, 32'h0);
        check("rst_a_pvalid", 32'(p_valid_a), 32'h0);
        check("rst_b_ack", 32'(ack_b), 32'h0);
        check("rst_b_data", data_b, 32'h0);
        check("rst_b_pvalid", 32'(p_valid_b), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] got;
        logic [31:0] popped[$];
        logic [11:0] offs [6];
        int          op;

        offs       = '{12'h000, 12'h000, 12'h004, 12'h008, 12'h010, 12'h00C};
        rst_n      = 1'b0;
        b_addr     = '0;
        b_wdata    = '0;
        b_read     = 1'b0;
        b_write    = 1'b0;
        p_ready    = 1'b0;
        p_ready_b  = 1'b0;
        rand_ready = 1'b0;
        exp_b      = '0;
        @(posedge clk);
        do_reset();
        tick(1'b0, 1'b0);

        // Scratch write/read with one wait state.
        txn(1'b0, 1'b0, 1'b1, 32'h4000_0008, 32'hDEAD_BEEF, d);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0, d);
        check("scratch_rd", d, 32'hDEAD_BEEF);

        // Fill FIFO with peripheral stalled, then overflow.
        for (int i = 1; i <= 8; i++) txn(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'hA500_0000 + 32'(i), d);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, d);
        check("status_full", d, 32'h0000_0048);
        txn(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'hA500_0009, d);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, d);
        check("status_ovf", d, 32'h0000_0148);
        check("head_kept", p_data_a, 32'hA500_0001);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, d);
        check("txdata_rd", d, 32'h0);

        // Clear overflow, then push into a full FIFO while popping on that edge.
        txn(1'b0, 1'b0, 1'b1, 32'h4000_0004, 32'h0000_0100, d);
        b_addr  = 32'h4000_0000;
        b_wdata = 32'hA500_0009;
        b_write = 1'b1;
        tick(1'b0, 1'b0);
        got = p_data_a;
        check("pop_order_1", got, 32'hA500_0001);
        p_ready = 1'b1;
        tick(1'b1, 1'b0);
        p_ready = 1'b0;
        b_write = 1'b0;
        tick(1'b0, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, d);
        check("status_full_no_ovf", d, 32'h0000_0048);
        p_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (p_valid_a) popped.push_back(p_data_a);
            tick(1'b0, 1'b0);
        end
        p_ready = 1'b0;
        check("drain_len", 32'(popped.size()), 32'd8);
        for (int i = 0; i < popped.size(); i++) check("pop_order", popped[i], 32'hA500_0002 + 32'(i));

        // Abort in WAIT on both instances; no side effect, next request normal.
        txn(1'b1, 1'b0, 1'b1, 32'h5000_0008, 32'h1111_1111, d);
        abort_write(32'h5000_0008, 32'h2222_2222, 2);
        txn(1'b1, 1'b1, 1'b0, 32'h5000_0008, 32'h0, d);
        check("b_scratch_after_abort", d, 32'h1111_1111);
        abort_write(32'h4000_0008, 32'h3333_3333, 1);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0, d);
        check("a_scratch_after_abort", d, 32'hDEAD_BEEF);
        txn(1'b1, 1'b1, 1'b0, 32'h5000_0004, 32'h0, d);
        check("b_status_empty", d, 32'h0000_0020);

        // Off-page requests never acked; unmapped offset acked with zero.
        no_ack(32'h4000_1004, 12);
        no_ack(32'h3FFF_F004, 12);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0010, 32'h0, d);
        check("unmapped_rd", d, 32'h0);
        txn(1'b0, 1'b1, 1'b1, 32'h4000_0008, 32'h5555_AAAA, d);
        check("rw_both_data", d, 32'h0);

        // Reset while a TXDATA write waits in WAIT.
        txn(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'hC000_0001, d);
        txn(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'hC000_0002, d);
        b_addr  = 32'h4000_0000;
        b_wdata = 32'hC000_0003;
        b_write = 1'b1;
        tick(1'b0, 1'b0);
        do_reset();
        b_write = 1'b0;
        tick(1'b0, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'h0, d);
        check("status_after_rst", d, 32'h0000_0020);
        txn(1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0, d);
        check("scratch_after_rst", d, 32'h0);

        // Random traffic with a randomly stalling peripheral.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 4));
            d  = $urandom;
            txn(1'b0, op == 0 || op == 2, op != 0, {20'h40000, offs[$urandom_range(0, 5)]}, d, got);
        end
        rand_ready = 1'b0;
        p_ready    = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
